scramble_lane: RTL

- Parametrised 100BASE-X stream scrambler/descrambler. Polynomial x^11 + x^9 + 1, key = s[8] ^ s[10].
- Processes WIDTH bits per valid cycle. Sits between the 4B5B coder and NRZI/PMA on TX, and mirrors that position on RX.
- Descramble mode adds idle-based self-synchronisation, a lock indicator and lock-loss detection.

---
 rtl/scramble_lane.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/scramble_lane.sv
// 100BASE-X stream scrambler / self-synchronising descrambler, polynomial x^11 + x^9 + 1.
// WIDTH bits per valid cycle (bit WIDTH-1 earliest), one-cycle registered latency.
module scramble_lane #(
    parameter int WIDTH         = 1,
    parameter int DESCRAMBLE    = 0,
    parameter int LOCK_BITS     = 30,
    parameter int IDLE_RUN      = 30,
    parameter int UNLOCK_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             seed_load,
    input  logic [10:0]      seed,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             locked
);
    localparam int MW = $clog2(LOCK_BITS + 1);
    localparam int RW = $clog2(IDLE_RUN + 1);
    localparam int WW = $clog2(UNLOCK_CYCLES + 1);

    localparam logic [MW-1:0] MATCH_MAX = MW'(LOCK_BITS);
    localparam logic [RW-1:0] RUN_MAX   = RW'(IDLE_RUN);
    localparam logic [WW-1:0] WDOG_MAX  = WW'(UNLOCK_CYCLES);
    localparam logic [10:0]   LFSR_RST  = 11'h7ff;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [10:0]     lfsr_q, lfsr_d;
    logic [MW-1:0]   match_q, match_d;
    logic [RW-1:0]   run_q, run_d;
    logic [WW-1:0]   wdog_q, wdog_d;
    logic            out_valid_q;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic key_b;
    logic obit_b;
    logic sight_b;

    // Streaming handshake: in_valid qualifies in_data for exactly one cycle, there is
    // no backpressure, and out_valid is in_valid delayed by one clock.
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        match_d    = match_q;
        run_d      = run_q;
        wdog_d     = wdog_q;
        out_data_d = out_data_q;
        key_b      = 1'b0;
        obit_b     = 1'b0;
        sight_b    = 1'b0;

        // A zero seed would lock the LFSR at all-zeros, so it maps to the reset state.
        if ((DESCRAMBLE == 0) && seed_load) begin
            lfsr_d = (seed == 11'd0) ? LFSR_RST : seed;
        end

        if (in_valid) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                key_b         = lfsr_d[8] ^ lfsr_d[10];
                obit_b        = in_data[i] ^ key_b;
                out_data_d[i] = obit_b;

                if (DESCRAMBLE == 0) begin
                    lfsr_d = {lfsr_d[9:0], key_b};
                end else if (state_d == UNLOCKED) begin
                    // Idle is all ones, so the received bit is the inverted key.
                    lfsr_d = {lfsr_d[9:0], ~in_data[i]};
                    if (key_b == ~in_data[i]) begin
                        if (match_d != MATCH_MAX) begin
                            match_d = match_d + MW'(1);
                        end
                    end else begin
                        match_d = '0;
                    end
                    if (match_d == MATCH_MAX) begin
                        state_d = LOCKED;
                    end
                end else begin
                    lfsr_d = {lfsr_d[9:0], key_b};
                    if (obit_b) begin
                        if (run_d != RUN_MAX) begin
                            run_d = run_d + RW'(1);
                        end
                    end else begin
                        run_d = '0;
                    end
                    if (run_d == RUN_MAX) begin
                        sight_b = 1'b1;
                    end
                end
            end

            // Watchdog only counts words that began locked; a sighting beats expiry.
            if ((DESCRAMBLE != 0) && (state_q == LOCKED)) begin
                if (sight_b) begin
                    wdog_d = '0;
                end else if (wdog_d != WDOG_MAX) begin
                    wdog_d = wdog_d + WW'(1);
                end
                if (wdog_d == WDOG_MAX) begin
                    state_d = UNLOCKED;
                    match_d = '0;
                    run_d   = '0;
                    wdog_d  = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= UNLOCKED;
            lfsr_q      <= LFSR_RST;
            match_q     <= '0;
            run_q       <= '0;
            wdog_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            match_q     <= match_d;
            run_q       <= run_d;
            wdog_q      <= wdog_d;
            out_valid_q <= in_valid;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign locked    = (DESCRAMBLE != 0) && (state_q == LOCKED);

endmodule
